// File: rtl/simple_pit_if.sv
// simple_pit_if: CPU I/O byte port (data 0x40, control 0x43) for the interval timer
interface simple_pit_if;
    logic       wr;
    logic       rd;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    modport master (output wr, rd, addr, din, input dout);
    modport slave  (input wr, rd, addr, din, output dout);
endinterface

// File: rtl/simple_pit.sv
// simple_pit: single-channel 8254 counter-0 subset (modes 2/3, binary only) driving irq0
module simple_pit #(
    parameter logic [15:0] RELOAD_RST = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_en,
    simple_pit_if.slave bus,
    output logic        out0,
    output logic        irq0
);
    logic [1:0]  mode, rw;
    logic [15:0] reload, latch, rd_src;
    logic [16:0] count, count_nx, reload_eff;
    logic        run, run_nx, out0_nx, out0_d, wff, rff, latched, load_pend;
    logic        ctrl_wr, cfg_wr, latch_wr, data_wr, data_rd, load;

    assign ctrl_wr    = bus.wr && bus.addr == 2'd3 && bus.din[7:6] == 2'b00;
    assign cfg_wr     = ctrl_wr && bus.din[5:4] != 2'b00;
    assign latch_wr   = ctrl_wr && bus.din[5:4] == 2'b00;
    assign data_wr    = bus.wr && bus.addr == 2'd0;
    assign data_rd    = bus.rd && bus.addr == 2'd0;
    assign load       = tick_en && load_pend;
    assign reload_eff = reload == 16'd0 ? 17'h10000 : {1'b0, reload};
    assign rd_src     = latched ? latch : count[15:0];

    always_comb begin
        count_nx = count;
        if (load)
            count_nx = reload_eff;
        else if (tick_en && run)
            count_nx = count == 17'd1 ? reload_eff : count - 17'd1;
        run_nx  = (run || load) && !cfg_wr;
        out0_nx = !run_nx || (mode == 2'd2 ? count_nx != 17'd1 : count_nx > (reload_eff >> 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode      <= 2'd3;
            rw        <= 2'b11;
            reload    <= RELOAD_RST;
            latch     <= 16'h0000;
            count     <= 17'd0;
            run       <= 1'b0;
            wff       <= 1'b0;
            rff       <= 1'b0;
            latched   <= 1'b0;
            load_pend <= 1'b0;
            out0      <= 1'b1;
            out0_d    <= 1'b1;
            irq0      <= 1'b0;
            bus.dout  <= 8'h00;
        end else begin
            count  <= count_nx;
            run    <= run_nx;
            out0   <= out0_nx;
            // a reconfiguration's forced high must not look like a rising edge
            out0_d <= cfg_wr || out0;
            irq0   <= out0 && !out0_d;
            if (load)
                load_pend <= 1'b0;
            if (bus.rd)
                bus.dout <= !data_rd ? 8'hFF :
                            (rw == 2'b10 || (rw == 2'b11 && rff)) ? rd_src[15:8] : rd_src[7:0];
            if (data_rd && rw == 2'b11)
                rff <= !rff;
            if (data_rd && (rw != 2'b11 || rff))
                latched <= 1'b0;
            if (latch_wr && !latched) begin
                latch   <= count[15:0];
                latched <= 1'b1;
            end
            if (cfg_wr) begin
                rw        <= bus.din[5:4];
                mode      <= bus.din[2:1] == 2'b10 ? 2'd2 : 2'd3;
                wff       <= 1'b0;
                rff       <= 1'b0;
                latched   <= 1'b0;
                load_pend <= 1'b0;
            end
            if (data_wr) begin
                if (rw == 2'b01)
                    reload <= {8'h00, bus.din};
                else if (rw == 2'b10)
                    reload <= {bus.din, 8'h00};
                else if (!wff)
                    reload[7:0] <= bus.din;
                else
                    reload[15:8] <= bus.din;
                wff <= rw == 2'b11 && !wff;
                if (rw != 2'b11 || wff)
                    load_pend <= 1'b1;
            end
        end
    end
endmodule

// File: doc/simple_pit.md
# simple_pit

Single-channel programmable interval timer, 8254 counter-0 compatible subset, for the Zet SoC. Sits directly upstream of the interrupt controller: its `irq0` drives the controller's `int[0]` input. It takes the CPU I/O byte writes/reads for ports 0x40 (data) and 0x43 (control), and `tick_en` (1.193 MHz enable derived from `clk`).

## Interface
- `RELOAD_RST`, default 16'h0000: reload value after reset (0 encodes 65536).
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous reset, active-high.
- `tick_en`  in  1  count enable, one `clk` wide per timer tick.
- `wr`  in  1  I/O byte write strobe, one cycle.
- `rd`  in  1  I/O byte read strobe, one cycle.
- `addr`  in  2  0 = counter-0 data, 3 = control word, 1/2 = ignored (reads 8'hFF).
- `din`  in  8  write data.
- `dout`  out  8  read data, registered.
- `out0`  out  1  timer output level (registered).
- `irq0`  out  1  one-`clk` pulse on each rising edge of `out0`; feeds `int[0]` downstream.

## Operation
- Registers: `mode` (2 or 3), `rw` (2 bits), `reload` (16), `count` (17 bits; 0 reload loads 65536), `run` flag, write byte flip-flop `wff`, read byte flip-flop `rff`, `latch` (16) plus `latched` flag, `load_pend` flag.
- Control write (`wr`, `addr`=3):
  - `din[7:6]` != 00: ignored entirely.
  - `din[5:4]` = 00: latch command. Copy `count[15:0]` into `latch` and set `latched`, unless already latched (then ignored). `mode`/`run` unchanged.
  - otherwise: `rw`<=`din[5:4]`; `mode`<=2 if `din[2:1]`=2'b10, else 3; `run`<=0, `out0`<=1, `wff`<=0, `rff`<=0, `latched`<=0. `din[0]` (BCD) is ignored; the counter is binary only.
- Data write (`addr`=0):
  - `rw`=01 sets `reload`={8'h00,din}.
  - `rw`=10 sets `reload`={din,8'h00}.
  - `rw`=11: first write sets low byte and sets `wff`. Second write sets high byte and clears `wff`.
  - A completed write sets `load_pend`.
- Load: on the first `tick_en` with `load_pend`=1, `count`<=(`reload`==0 ? 65536 : `reload`), `run`<=1, `load_pend`<=0. This tick does not decrement.
- Counting: on `tick_en` with `run`=1 and no pending load:
  - if `count`==1, `count`<=reload value (0 maps to 65536);
  - else `count`<=`count`-1.
- `out0` is registered from the next-state `count` and is forced to 1 when `run`=0:
  - mode 2: `out0` = (`count` != 1).
  - mode 3: `out0` = (`count` > `reload_eff`>>1), where `reload_eff` is the 17-bit reload value. This gives high for ceil(N/2) ticks and low for floor(N/2) ticks.
- `irq0`: registered `out0 & !out0_d`. It is high exactly one cycle per period.
- Read (`rd`, `addr`=0):
  - Source is `latch` if `latched`, else live `count[15:0]`.
  - `rw`=01 returns the low byte; `rw`=10 returns the high byte.
  - `rw`=11 returns low then high, toggling `rff`.
  - `latched` clears after the final byte of the access mode has been read.
- Read on `addr`≠0 returns 8'hFF. `dout` holds its value when `rd`=0.

## Timing
- Reset values: `out0`=1, `irq0`=0, `dout`=8'h00, `count`=0, `run`=0, `mode`=3, `rw`=11, `reload`=`RELOAD_RST`, all flags 0.
- `dout` is valid the cycle after `rd`.
- Register writes take effect at the `clk` edge where `wr`=1.
- Write completion and `tick_en` in the same cycle: the load occurs on the next `tick_en`, not this one.
- Mode 2, N≥2: `out0` is low for one tick out of every N. `irq0` pulses one `clk` after `out0` returns high.
- A control write mid-count stops the counter immediately: `out0`=1 the next cycle, and no `irq0` pulse is generated by that forced rise.
- A control write between the two bytes of an `rw`=11 sequence restarts the byte sequence.
- `rd` and `wr` in the same cycle: both are performed, and the read returns pre-write state.
- Reset mid-operation returns every register to its reset value the next cycle.

## Test plan
- Reset, then write 0x43←0x34, 0x40←0x03, 0x40←0x00, with `tick_en` every cycle. Required: after load, `out0` low 1 tick in every 3 and `irq0` period exactly 3 cycles.
- Write 0x43←0x36, data 0x05/0x00, `tick_en` every 4th cycle. Required: `out0` high 3 ticks, low 2 ticks, repeating; one `irq0` per 20 clocks.
- Write 0x43←0x36 with data 0x00/0x00. Required: period 65536 ticks, `out0` high 32768 ticks.
- Running with count near 0x1234: write latch command 0x43←0x00, advance 10 ticks, then read 0x40 twice. Required: bytes 0x34, 0x12 (latched value). A third read returns the live low byte.
- Mid-count control write 0x43←0x34. Required: `out0`=1 next cycle, no `irq0`, and counting halts until both data bytes are written.
- Assert `rst` mid-period. Required: all outputs at reset values the next cycle, and reads of `addr` 1 return 0xFF.
